// File: rtl/bus_const_narrower_if.sv
// Constant-path bundle between the bus sampler and its operand consumer.
// master = bus/consumer side; slave = the narrowing block.
interface bus_const_narrower_if #(
  parameter int BUS_W   = 8,
  parameter int FIELD_W = 4
);
  logic [BUS_W-1:0]   dataBus;
  logic               ld;
  logic               ldReady;
  logic [FIELD_W-1:0] constOut;
  logic               constOvf;
  logic               constValid;
  logic               constReady;
  logic               dropErr;
  logic [7:0]         satCount;
  logic               clrErr;

  modport master (
    output dataBus, ld, constReady, clrErr,
    input  ldReady, constOut, constOvf, constValid, dropErr, satCount
  );

  modport slave (
    input  dataBus, ld, constReady, clrErr,
    output ldReady, constOut, constOvf, constValid, dropErr, satCount
  );
endinterface

// File: rtl/bus_const_narrower.sv
// Samples the data bus on ld, saturates it to a signed FIELD_W operand and queues it; 1-cycle
// capture-to-valid latency, ldReady is a registered !full, and loads arriving while full are dropped and flagged.
module bus_const_narrower #(
  parameter int BUS_W   = 8,
  parameter int FIELD_W = 4,
  parameter int DEPTH   = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  bus_const_narrower_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic signed [BUS_W-1:0] SMAX = BUS_W'((1 <<< (FIELD_W - 1)) - 1);
  localparam logic signed [BUS_W-1:0] SMIN = BUS_W'(-(1 <<< (FIELD_W - 1)));
  localparam logic [FIELD_W-1:0] FMAX = {1'b0, {(FIELD_W - 1){1'b1}}};
  localparam logic [FIELD_W-1:0] FMIN = {1'b1, {(FIELD_W - 1){1'b0}}};

  logic [FIELD_W:0]   mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic               ld_ready_q;
  logic               drop_err_q;
  logic [7:0]         sat_cnt_q;
  logic [FIELD_W-1:0] field;
  logic               ovf;
  logic               push, pop, drop, empty, full_nxt;
  logic signed [BUS_W-1:0] v;

  assign v = $signed(bus.dataBus);

  always_comb begin
    field = bus.dataBus[FIELD_W-1:0];
    ovf   = 1'b0;
    if (v > SMAX) begin
      field = FMAX;
      ovf   = 1'b1;
    end else if (v < SMIN) begin
      field = FMIN;
      ovf   = 1'b1;
    end
  end

  // A full FIFO refuses the load even if the consumer pops on the same edge.
  assign empty      = (wr_ptr == rd_ptr);
  assign push       = bus.ld & ld_ready_q;
  assign drop       = bus.ld & ~ld_ready_q;
  assign pop        = ~empty & bus.constReady;
  assign wr_ptr_nxt = wr_ptr + PW'(push);
  assign rd_ptr_nxt = rd_ptr + PW'(pop);
  assign full_nxt   = (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ld_ready_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      ld_ready_q <= ~full_nxt;
      if (push) mem[wr_ptr[AW-1:0]] <= {ovf, field};
    end
  end

  // clrErr outranks any drop or saturation landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err_q <= 1'b0;
      sat_cnt_q  <= 8'd0;
    end else if (bus.clrErr) begin
      drop_err_q <= 1'b0;
      sat_cnt_q  <= 8'd0;
    end else begin
      if (drop) drop_err_q <= 1'b1;
      if (push && ovf && sat_cnt_q != 8'hFF) sat_cnt_q <= sat_cnt_q + 8'd1;
    end
  end

  assign bus.ldReady    = ld_ready_q;
  assign bus.constValid = ~empty;
  assign bus.constOut   = mem[rd_ptr[AW-1:0]][FIELD_W-1:0];
  assign bus.constOvf   = mem[rd_ptr[AW-1:0]][FIELD_W];
  assign bus.dropErr    = drop_err_q;
  assign bus.satCount   = sat_cnt_q;
endmodule
